data_sram_bridge: RTL and testbench
===================================

# data_sram_bridge

Data-side memory port bridge sitting directly downstream of the `mem` stage. It consumes the stage's request/handshake bus (`data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`) and returns `data_addr_ok`, `data_data_ok` and `data_rdata`. It drives a single-port synchronous data SRAM with byte enables and a configurable number of wait states, and flags misaligned accesses instead of performing them.

## Interface
- `WAIT_STATES`, default 1: extra SRAM access cycles beyond the first; legal range 0..7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_req` in 1: request valid from `mem`.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `data_addr` in 32: physical byte address.
- `data_wdata` in 32: store data, already lane-replicated by `mem`.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: one-cycle response pulse.
- `data_rdata` out 32: full SRAM word, valid while `data_data_ok` is high.
- `addr_err` out 1: pulses together with `data_data_ok` when the request was misaligned.
- `sram_en` out 1: SRAM chip enable.
- `sram_we` out 4: byte write enables.
- `sram_addr` out 30: word address (`data_addr[31:2]`).
- `sram_wdata` out 32: store data.
- `sram_rdata` in 32: SRAM read data, valid during the final access cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- `data_addr_ok = data_req && (state==IDLE || state==RESP)`. This is combinational, with no dependence on `data_wr` or alignment.
- On an accepting edge, register the following, then enter ACCESS with `wait_cnt = WAIT_STATES`:
  - `data_addr[31:2]` and `data_wdata`;
  - a write flag, a misaligned flag, and the byte mask.
- Byte mask from `data_size` and `addr[1:0]`:
  - byte: 0001 shifted left by `addr[1:0]`;
  - half: 0011 if `addr[1]==0`, otherwise 1100;
  - word, or reserved size: 1111.
- Misaligned means half with `addr[0]==1`, or word/reserved with `addr[1:0]!=0`.
- ACCESS:
  - `sram_en` = !misaligned; `sram_we` = write && !misaligned ? mask : 0000.
  - `sram_addr` and `sram_wdata` come from the registers.
  - `wait_cnt` decrements each cycle. When it is 0, the next edge captures `sram_rdata` into `rdata_q` and moves to RESP. Capture `rdata_q` = 0 for misaligned accesses or stores.
- RESP:
  - `data_data_ok` = 1; `data_rdata` = `rdata_q`; `addr_err` = misaligned flag.
  - Next state is ACCESS if a new request is accepted this cycle, otherwise IDLE.
- Outside ACCESS, `sram_en`=0 and `sram_we`=0000; `sram_addr` and `sram_wdata` hold their last values.
- Responses are strictly in order, with at most one outstanding request.

## Timing
- Reset (`rst` low, any time, asynchronous):
  - state goes to IDLE, and all registers clear to 0;
  - all outputs are 0 except the combinational `data_addr_ok` (0 in reset);
  - an in-flight access is dropped and produces no response.
- Latency: accepted in cycle 0 → ACCESS in cycles 1..WAIT_STATES+1 → `data_data_ok` in cycle WAIT_STATES+2.
- Back-to-back: a request accepted in the RESP cycle starts ACCESS the next cycle, giving a throughput of one request per WAIT_STATES+2 cycles.
- `data_req` held during ACCESS is ignored (no `data_addr_ok`). The requester keeps it asserted or re-asserts it later.
- `data_data_ok` and `data_addr_ok` may both be high in the same cycle (RESP with a new request). The response belongs to the older request.
- `data_req` dropping mid-access has no effect; the accepted transaction completes.

## Structure
- The shared package holds the `data_size` encodings (SIZE_B/H/W) and the FSM state enum. `WAIT_STATES` stays a module parameter.
- One natural sub-module: `byte_mask_gen`. It is combinational and maps size and `addr[1:0]` to {mask[3:0], misaligned}, and is reusable by a future instruction-side bridge.

## Test plan
- **Byte store, `WAIT_STATES=1`:** SB addr 0x103, wdata 0xABABABAB.
  - Cycle 0: `addr_ok`.
  - Cycles 1–2: `sram_en`=1, `sram_we`=1000, `sram_addr`=0x40.
  - Cycle 3: `data_ok`=1, `addr_err`=0.
- **Word load, `WAIT_STATES=0`:** LW addr 0x200, SRAM returns 0xDEADBEEF.
  - Cycle 1: `sram_we`=0000.
  - Cycle 2: `data_ok`=1, `data_rdata`=0xDEADBEEF.
- **Misaligned half:** LH addr 0x201.
  - `sram_en` stays 0 throughout.
  - `data_ok` and `addr_err` both pulse at cycle WAIT_STATES+2, with `data_rdata`=0.
- **Back-to-back:** `data_req` held high for 3 requests with `WAIT_STATES=2`.
  - `addr_ok` at cycles 0, 4, 8; `data_ok` at cycles 4, 8, 12.
  - Read data returns in order.
- **Reset mid-access:** drive `rst` low during cycle 2 of an ACCESS.
  - All outputs go to 0 immediately (asynchronously).
  - After release, no `data_ok` appears for the dropped request, and a new request completes normally.
- **Half store upper lane:** SH addr 0x32, wdata 0x12341234.
  - `sram_we`=1100, `sram_wdata`=0x12341234.

Source files
------------

// File: rtl/data_sram_bridge_pkg.sv
// Shared encodings for the data-side SRAM bridge: access sizes and FSM states.
package data_sram_bridge_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/data_sram_bridge_if.sv
// Request/response bus between the mem stage (master) and the data SRAM bridge (slave).
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        addr_err;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata, addr_err
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata, addr_err
  );
endinterface

// File: rtl/data_sram_bridge_mask.sv
// Combinational byte-lane mask and alignment check from access size and addr[1:0].
module byte_mask_gen
  import data_sram_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       misaligned
);

  always_comb begin
    mask       = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SIZE_B: mask = 4'b0001 << addr_lo;
      SIZE_H: begin
        mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      // word and the reserved encoding both take the full-word path
      default: begin
        mask       = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Data-side bridge from the mem stage handshake bus to a single-port synchronous SRAM.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  data_sram_bridge_if.slave   bus,
  output logic                sram_en,
  output logic [3:0]          sram_we,
  output logic [29:0]         sram_addr,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata
);

  state_t      state_q, state_d;
  logic [2:0]  wait_cnt_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  mask_q;
  logic        wr_q;
  logic        mis_q;
  logic [3:0]  mask_c;
  logic        mis_c;
  logic        accept;

  byte_mask_gen u_mask (
    .size       (bus.data_size),
    .addr_lo    (bus.data_addr[1:0]),
    .mask       (mask_c),
    .misaligned (mis_c)
  );

  // gated by rst so the combinational handshake is quiet while reset is held
  assign accept = rst && bus.data_req && (state_q == IDLE || state_q == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mask_q     <= '0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wait_cnt_q <= 3'(WAIT_STATES);
        addr_q     <= bus.data_addr[31:2];
        wdata_q    <= bus.data_wdata;
        mask_q     <= mask_c;
        wr_q       <= bus.data_wr;
        mis_q      <= mis_c;
      end else if (state_q == ACCESS) begin
        if (wait_cnt_q != '0) begin
          wait_cnt_q <= wait_cnt_q - 3'd1;
        end else begin
          rdata_q <= (wr_q || mis_q) ? '0 : sram_rdata;
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    sram_en          = 1'b0;
    sram_we          = '0;
    bus.data_data_ok = 1'b0;
    bus.addr_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        sram_en = !mis_q;
        sram_we = (wr_q && !mis_q) ? mask_q : 4'b0000;
        if (wait_cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        bus.data_data_ok = 1'b1;
        bus.addr_err     = mis_q;
        state_d          = accept ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_addr_ok = accept;
  assign bus.data_rdata   = rdata_q;
  assign sram_addr        = addr_q;
  assign sram_wdata       = wdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench: three bridge instances with WAIT_STATES 1, 0 and 2.
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  data_sram_bridge_if b0 ();
  data_sram_bridge_if b1 ();
  data_sram_bridge_if b2 ();

  logic        en0, en1, en2;
  logic [3:0]  we0, we1, we2;
  logic [29:0] sa0, sa1, sa2;
  logic [31:0] sw0, sw1, sw2;
  logic [31:0] sr0, sr1, sr2;

  assign sr0 = 32'hDEAD_BEEF;
  assign sr1 = 32'h0F0F_0F0F;
  // address-dependent read data makes response ordering observable
  assign sr2 = {2'b00, sa2} ^ 32'h5A5A_5A5A;

  data_sram_bridge #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .sram_en(en0), .sram_we(we0),
    .sram_addr(sa0), .sram_wdata(sw0), .sram_rdata(sr0));
  data_sram_bridge #(.WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .sram_en(en1), .sram_we(we1),
    .sram_addr(sa1), .sram_wdata(sw1), .sram_rdata(sr1));
  data_sram_bridge #(.WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave), .sram_en(en2), .sram_we(we2),
    .sram_addr(sa2), .sram_wdata(sw2), .sram_rdata(sr2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    b0.data_req = 0; b0.data_wr = 0; b0.data_size = SIZE_W; b0.data_addr = '0; b0.data_wdata = '0;
    b1.data_req = 0; b1.data_wr = 0; b1.data_size = SIZE_W; b1.data_addr = '0; b1.data_wdata = '0;
    b2.data_req = 0; b2.data_wr = 0; b2.data_size = SIZE_W; b2.data_addr = '0; b2.data_wdata = '0;

    // reset state, with a request presented while reset is held
    @(negedge clk);
    b1.data_req = 1;
    #1;
    chk("rst_addr_ok", 32'(b1.data_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(b1.data_data_ok), 32'd0);
    chk("rst_en", 32'(en1), 32'd0);
    chk("rst_we", 32'(we1), 32'd0);
    chk("rst_saddr", 32'(sa1), 32'd0);
    chk("rst_rdata", b1.data_rdata, 32'd0);
    b1.data_req = 0;
    rst = 1'b1;
    @(negedge clk);

    // SB 0x103, WAIT_STATES=1
    @(negedge clk);
    b1.data_req = 1; b1.data_wr = 1; b1.data_size = SIZE_B;
    b1.data_addr = 32'h103; b1.data_wdata = 32'hABAB_ABAB;
    #1; chk("sb_addr_ok", 32'(b1.data_addr_ok), 32'd1);
    @(negedge clk); b1.data_req = 0; #1;
    chk("sb_c1_en", 32'(en1), 32'd1);
    chk("sb_c1_we", 32'(we1), 32'h8);
    chk("sb_c1_saddr", 32'(sa1), 32'h40);
    chk("sb_c1_wdata", sw1, 32'hABAB_ABAB);
    @(negedge clk); #1;
    chk("sb_c2_en", 32'(en1), 32'd1);
    chk("sb_c2_we", 32'(we1), 32'h8);
    chk("sb_c2_data_ok", 32'(b1.data_data_ok), 32'd0);
    @(negedge clk); #1;
    chk("sb_c3_data_ok", 32'(b1.data_data_ok), 32'd1);
    chk("sb_c3_addr_err", 32'(b1.addr_err), 32'd0);
    chk("sb_c3_en", 32'(en1), 32'd0);
    @(negedge clk); #1;
    chk("sb_c4_data_ok", 32'(b1.data_data_ok), 32'd0);

    // LW 0x200, WAIT_STATES=0
    @(negedge clk);
    b0.data_req = 1; b0.data_wr = 0; b0.data_size = SIZE_W; b0.data_addr = 32'h200;
    #1; chk("lw_addr_ok", 32'(b0.data_addr_ok), 32'd1);
    @(negedge clk); b0.data_req = 0; #1;
    chk("lw_c1_en", 32'(en0), 32'd1);
    chk("lw_c1_we", 32'(we0), 32'd0);
    chk("lw_c1_saddr", 32'(sa0), 32'h80);
    @(negedge clk); #1;
    chk("lw_c2_data_ok", 32'(b0.data_data_ok), 32'd1);
    chk("lw_c2_rdata", b0.data_rdata, 32'hDEAD_BEEF);
    chk("lw_c2_addr_err", 32'(b0.addr_err), 32'd0);

    // LH 0x201 misaligned, WAIT_STATES=0
    @(negedge clk);
    b0.data_req = 1; b0.data_size = SIZE_H; b0.data_addr = 32'h201;
    #1; chk("mh_addr_ok", 32'(b0.data_addr_ok), 32'd1);
    @(negedge clk); b0.data_req = 0; #1;
    chk("mh_c1_en", 32'(en0), 32'd0);
    chk("mh_c1_we", 32'(we0), 32'd0);
    @(negedge clk); #1;
    chk("mh_c2_data_ok", 32'(b0.data_data_ok), 32'd1);
    chk("mh_c2_addr_err", 32'(b0.addr_err), 32'd1);
    chk("mh_c2_rdata", b0.data_rdata, 32'd0);
    chk("mh_c2_en", 32'(en0), 32'd0);

    // back-to-back loads with req held, WAIT_STATES=2
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      b2.data_req  = (c <= 8);
      b2.data_wr   = 0;
      b2.data_size = SIZE_W;
      b2.data_addr = (c < 4) ? 32'h100 : (c < 8) ? 32'h104 : 32'h108;
      #1;
      chk($sformatf("b2b_addr_ok_c%0d", c), 32'(b2.data_addr_ok),
          32'((c == 0) || (c == 4) || (c == 8)));
      chk($sformatf("b2b_data_ok_c%0d", c), 32'(b2.data_data_ok),
          32'((c == 4) || (c == 8) || (c == 12)));
      if (c == 4)  chk("b2b_rdata0", b2.data_rdata, 32'h5A5A_5A1A);
      if (c == 8)  chk("b2b_rdata1", b2.data_rdata, 32'h5A5A_5A1B);
      if (c == 12) chk("b2b_rdata2", b2.data_rdata, 32'h5A5A_5A18);
    end

    // LW 0x300 dropped by reset during its second ACCESS cycle, WAIT_STATES=1
    @(negedge clk);
    b1.data_req = 1; b1.data_wr = 0; b1.data_size = SIZE_W;
    b1.data_addr = 32'h300; b1.data_wdata = 32'h5555_5555;
    #1; chk("rm_addr_ok", 32'(b1.data_addr_ok), 32'd1);
    @(negedge clk); #1;
    chk("rm_c1_en", 32'(en1), 32'd1);
    @(negedge clk); #1;
    chk("rm_c2_en", 32'(en1), 32'd1);
    rst = 1'b0;
    #1;
    chk("rm_async_en", 32'(en1), 32'd0);
    chk("rm_async_saddr", 32'(sa1), 32'd0);
    chk("rm_async_wdata", sw1, 32'd0);
    chk("rm_async_addr_ok", 32'(b1.data_addr_ok), 32'd0);
    chk("rm_async_data_ok", 32'(b1.data_data_ok), 32'd0);
    @(negedge clk);
    b1.data_req = 0;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rm_no_resp_%0d", c), 32'(b1.data_data_ok), 32'd0);
    end

    // SH 0x32 upper lane after reset recovery, WAIT_STATES=1
    @(negedge clk);
    b1.data_req = 1; b1.data_wr = 1; b1.data_size = SIZE_H;
    b1.data_addr = 32'h32; b1.data_wdata = 32'h1234_1234;
    #1; chk("sh_addr_ok", 32'(b1.data_addr_ok), 32'd1);
    @(negedge clk); b1.data_req = 0; #1;
    chk("sh_c1_en", 32'(en1), 32'd1);
    chk("sh_c1_we", 32'(we1), 32'hC);
    chk("sh_c1_saddr", 32'(sa1), 32'hC);
    chk("sh_c1_wdata", sw1, 32'h1234_1234);
    @(negedge clk); #1;
    chk("sh_c2_we", 32'(we1), 32'hC);
    @(negedge clk); #1;
    chk("sh_c3_data_ok", 32'(b1.data_data_ok), 32'd1);
    chk("sh_c3_addr_err", 32'(b1.addr_err), 32'd0);
    chk("sh_c3_saddr_hold", 32'(sa1), 32'hC);
    chk("sh_c3_we", 32'(we1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
